// File: rtl/dummy_cu_multi_if.sv
// CPU handshake and datapath control bundle for the multi-unit dummy coprocessor control unit.
// The slave side is the control unit; the master side is the CPU/datapath environment.
interface dummy_cu_multi_if #(
  parameter int unsigned NUM_ITER = 2
);
  localparam int unsigned SEL_W = (NUM_ITER > 1) ? $clog2(NUM_ITER) : 1;

  logic                valid_i;
  logic                ready_o;
  logic                comb_mode_i;
  logic                valid_o;
  logic                ready_i;
  logic                pipe_valid_i;
  logic                pipe_en_o;
  logic [NUM_ITER-1:0] iter_start_o;
  logic [NUM_ITER-1:0] iter_en_o;
  logic [SEL_W-1:0]    iter_sel_o;

  modport slave (
    input  valid_i, comb_mode_i, ready_i, pipe_valid_i,
    output ready_o, valid_o, pipe_en_o, iter_start_o, iter_en_o, iter_sel_o
  );

  modport master (
    output valid_i, comb_mode_i, ready_i, pipe_valid_i,
    input  ready_o, valid_o, pipe_en_o, iter_start_o, iter_en_o, iter_sel_o
  );
endinterface

// File: rtl/dummy_cu_multi.sv
// Control unit for the dummy coprocessor: pipelined path with an in-flight credit limit, plus
// NUM_ITER iterative units dispatched round-robin and retired in dispatch order.
package dummy_pkg;
  typedef enum logic {
    MODE_PIPE = 1'b0,
    MODE_ITER = 1'b1
  } coproc_ctl_t;

  typedef enum logic [1:0] {
    RES_SEL_COMB = 2'd0,
    RES_SEL_PIPE = 2'd1,
    RES_SEL_ITER = 2'd2
  } res_sel_t;

  typedef enum logic [1:0] {
    ST_RESET = 2'd0,
    ST_IDLE  = 2'd1,
    ST_PIPE  = 2'd2,
    ST_ITER  = 2'd3
  } cu_state_t;
endpackage

module dummy_cu_multi
  import dummy_pkg::*;
#(
  parameter int unsigned NUM_ITER    = 2,
  parameter int unsigned ITER_CYCLES = 4,
  parameter int unsigned PIPE_DEPTH  = 3
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        flush_i,
  input  coproc_ctl_t ctl_i,
  output res_sel_t    res_sel_o,
  dummy_cu_multi_if.slave bus
);
  localparam int unsigned PTR_W = (NUM_ITER > 1) ? $clog2(NUM_ITER) : 1;
  localparam int unsigned CNT_W = $clog2(ITER_CYCLES + 1);
  localparam int unsigned CRD_W = $clog2(PIPE_DEPTH + 1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(NUM_ITER - 1);
  localparam logic [CNT_W-1:0] ITER_MAX = CNT_W'(ITER_CYCLES);
  localparam logic [CRD_W-1:0] CRD_MAX  = CRD_W'(PIPE_DEPTH);

  cu_state_t           state_r, state_s;
  logic [CNT_W-1:0]    cnt_r [NUM_ITER];
  logic [NUM_ITER-1:0] busy_r, busy_s;
  logic [NUM_ITER-1:0] done_s, start_s, en_s;
  logic [PTR_W-1:0]    disp_ptr_r, disp_ptr_s;
  logic [PTR_W-1:0]    ret_ptr_r, ret_ptr_s;
  logic [CRD_W-1:0]    count_r, count_s;
  logic                accept_s, retire_s;
  logic                ready_s, valid_s, pipe_en_s;
  logic [PTR_W-1:0]    sel_s;
  res_sel_t            res_sel_s;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? {PTR_W{1'b0}} : p + PTR_W'(1);
  endfunction

  // A unit holds its result once its counter saturates, until it is retired.
  always_comb begin
    for (int k = 0; k < NUM_ITER; k++) begin
      done_s[k] = busy_r[k] & (cnt_r[k] == ITER_MAX);
    end
    en_s = busy_r & ~done_s;
  end

  // Next-state, bookkeeping and handshake outputs.
  always_comb begin
    state_s    = state_r;
    busy_s     = busy_r;
    disp_ptr_s = disp_ptr_r;
    ret_ptr_s  = ret_ptr_r;
    count_s    = count_r;
    start_s    = {NUM_ITER{1'b0}};
    accept_s   = 1'b0;
    retire_s   = 1'b0;
    ready_s    = 1'b0;
    valid_s    = 1'b0;
    pipe_en_s  = 1'b0;
    sel_s      = {PTR_W{1'b0}};
    res_sel_s  = RES_SEL_COMB;
    case (state_r)
      ST_RESET: begin
        state_s = ST_IDLE;
      end
      ST_IDLE: begin
        if (bus.comb_mode_i) begin
          valid_s = bus.valid_i;
          ready_s = bus.ready_i;
        end else begin
          ready_s = 1'b1;
          if (bus.valid_i) begin
            accept_s = 1'b1;
            if (ctl_i == MODE_PIPE) begin
              pipe_en_s = 1'b1;
              count_s   = CRD_W'(1);
              state_s   = ST_PIPE;
            end else begin
              start_s[disp_ptr_r] = 1'b1;
              busy_s[disp_ptr_r]  = 1'b1;
              disp_ptr_s          = ptr_inc(disp_ptr_r);
              state_s             = ST_ITER;
            end
          end else begin
            accept_s = 1'b0;
          end
        end
      end
      ST_PIPE: begin
        res_sel_s = RES_SEL_PIPE;
        valid_s   = bus.pipe_valid_i;
        pipe_en_s = bus.ready_i | ~bus.pipe_valid_i;
        // A full pipeline may still take a request when its head leaves in the same cycle.
        ready_s   = (ctl_i == MODE_PIPE) & pipe_en_s &
                    ((count_r < CRD_MAX) | (bus.pipe_valid_i & bus.ready_i));
        accept_s  = bus.valid_i & ready_s;
        retire_s  = bus.pipe_valid_i & bus.ready_i & (count_r != {CRD_W{1'b0}});
        count_s   = count_r + CRD_W'(accept_s) - CRD_W'(retire_s);
        if (count_s == {CRD_W{1'b0}}) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_PIPE;
        end
      end
      ST_ITER: begin
        res_sel_s = RES_SEL_ITER;
        sel_s     = ret_ptr_r;
        valid_s   = done_s[ret_ptr_r];
        // Dispatch looks at registered busy, so a unit retiring now is not reused until next cycle.
        ready_s   = (ctl_i == MODE_ITER) & ~busy_r[disp_ptr_r];
        accept_s  = bus.valid_i & ready_s;
        retire_s  = done_s[ret_ptr_r] & bus.ready_i;
        if (retire_s) begin
          busy_s[ret_ptr_r] = 1'b0;
          ret_ptr_s         = ptr_inc(ret_ptr_r);
        end else begin
          ret_ptr_s = ret_ptr_r;
        end
        if (accept_s) begin
          start_s[disp_ptr_r] = 1'b1;
          busy_s[disp_ptr_r]  = 1'b1;
          disp_ptr_s          = ptr_inc(disp_ptr_r);
        end else begin
          disp_ptr_s = disp_ptr_r;
        end
        if ((busy_s == {NUM_ITER{1'b0}}) && !accept_s) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_ITER;
        end
      end
      default: begin
        state_s = ST_RESET;
      end
    endcase
  end

  // State, pointers, credits and per-unit iteration counters.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r    <= ST_RESET;
      busy_r     <= {NUM_ITER{1'b0}};
      disp_ptr_r <= {PTR_W{1'b0}};
      ret_ptr_r  <= {PTR_W{1'b0}};
      count_r    <= {CRD_W{1'b0}};
      for (int k = 0; k < NUM_ITER; k++) begin
        cnt_r[k] <= {CNT_W{1'b0}};
      end
    end else if (flush_i) begin
      state_r    <= ST_RESET;
      busy_r     <= {NUM_ITER{1'b0}};
      disp_ptr_r <= {PTR_W{1'b0}};
      ret_ptr_r  <= {PTR_W{1'b0}};
      count_r    <= {CRD_W{1'b0}};
      for (int k = 0; k < NUM_ITER; k++) begin
        cnt_r[k] <= {CNT_W{1'b0}};
      end
    end else begin
      state_r    <= state_s;
      busy_r     <= busy_s;
      disp_ptr_r <= disp_ptr_s;
      ret_ptr_r  <= ret_ptr_s;
      count_r    <= count_s;
      for (int k = 0; k < NUM_ITER; k++) begin
        if (start_s[k]) begin
          cnt_r[k] <= CNT_W'(1);
        end else if (busy_r[k] && !busy_s[k]) begin
          cnt_r[k] <= {CNT_W{1'b0}};
        end else if (busy_r[k] && (cnt_r[k] < ITER_MAX)) begin
          cnt_r[k] <= cnt_r[k] + CNT_W'(1);
        end else begin
          cnt_r[k] <= cnt_r[k];
        end
      end
    end
  end

  assign bus.ready_o      = ready_s;
  assign bus.valid_o      = valid_s;
  assign bus.pipe_en_o    = pipe_en_s;
  assign bus.iter_start_o = start_s;
  assign bus.iter_en_o    = en_s;
  assign bus.iter_sel_o   = sel_s;
  assign res_sel_o        = res_sel_s;
endmodule

// File: tb/tb_dummy_cu_multi.sv
// Directed bench for dummy_cu_multi with NUM_ITER=2, ITER_CYCLES=4, PIPE_DEPTH=3.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
module tb_dummy_cu_multi;
  import dummy_pkg::*;

  logic        clk = 1'b0;
  logic        rst_ni = 1'b0;
  logic        flush_i = 1'b0;
  coproc_ctl_t ctl_i = MODE_PIPE;
  res_sel_t    res_sel_o;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  dummy_cu_multi_if #(.NUM_ITER(2)) bus ();

  dummy_cu_multi #(.NUM_ITER(2), .ITER_CYCLES(4), .PIPE_DEPTH(3)) dut (
    .clk_i     (clk),
    .rst_ni    (rst_ni),
    .flush_i   (flush_i),
    .ctl_i     (ctl_i),
    .res_sel_o (res_sel_o),
    .bus       (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_flush();
    tick();
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (dut.state_r !== ST_RESET) begin errors++; $display("FAIL rst_state: got %0d exp %0d", dut.state_r, ST_RESET); end
    checks++; if ({bus.valid_o, bus.ready_o, bus.pipe_en_o} !== 3'b000) begin errors++; $display("FAIL rst_hs: got %b exp 000", {bus.valid_o, bus.ready_o, bus.pipe_en_o}); end
    checks++; if ({bus.iter_start_o, bus.iter_en_o, bus.iter_sel_o} !== 5'b00000) begin errors++; $display("FAIL rst_iter: got %b exp 00000", {bus.iter_start_o, bus.iter_en_o, bus.iter_sel_o}); end
    checks++; if (res_sel_o !== RES_SEL_COMB) begin errors++; $display("FAIL rst_res_sel: got %0d exp %0d", res_sel_o, RES_SEL_COMB); end
    tick();
    rst_ni = 1'b1;
    @(negedge clk);
    checks++; if (dut.state_r !== ST_RESET) begin errors++; $display("FAIL rst_release_state: got %0d exp %0d", dut.state_r, ST_RESET); end
    tick();
    @(negedge clk);
    checks++; if (dut.state_r !== ST_IDLE) begin errors++; $display("FAIL rst_to_idle: got %0d exp %0d", dut.state_r, ST_IDLE); end
    checks++; if (bus.ready_o !== 1'b1) begin errors++; $display("FAIL idle_ready: got %b exp 1", bus.ready_o); end
  endtask

  task automatic test_comb();
    for (int i = 0; i < 4; i++) begin
      tick();
      bus.comb_mode_i = 1'b1;
      bus.valid_i = 1'b1;
      bus.ready_i = (i % 2) == 1;
      @(negedge clk);
      checks++; if (bus.valid_o !== 1'b1) begin errors++; $display("FAIL comb_valid[%0d]: got %b exp 1", i, bus.valid_o); end
      checks++; if (bus.ready_o !== ((i % 2) == 1)) begin errors++; $display("FAIL comb_ready[%0d]: got %b exp %b", i, bus.ready_o, (i % 2) == 1); end
      checks++; if (dut.state_r !== ST_IDLE) begin errors++; $display("FAIL comb_state[%0d]: got %0d exp %0d", i, dut.state_r, ST_IDLE); end
    end
    tick();
    bus.comb_mode_i = 1'b0;
    bus.valid_i = 1'b0;
    bus.ready_i = 1'b0;
  endtask

  task automatic test_iter_single();
    do_flush();
    tick();
    ctl_i = MODE_ITER; bus.valid_i = 1'b1; bus.ready_i = 1'b1;
    @(negedge clk);
    checks++; if (bus.iter_start_o !== 2'b01) begin errors++; $display("FAIL single_start: got %b exp 01", bus.iter_start_o); end
    checks++; if (bus.ready_o !== 1'b1) begin errors++; $display("FAIL single_ready: got %b exp 1", bus.ready_o); end
    for (int c = 1; c <= 3; c++) begin
      tick();
      bus.valid_i = 1'b0;
      @(negedge clk);
      checks++; if ({bus.valid_o, bus.iter_en_o} !== 3'b001) begin errors++; $display("FAIL single_busy[c%0d]: got %b exp 001", c, {bus.valid_o, bus.iter_en_o}); end
    end
    tick();
    @(negedge clk);
    checks++; if ({bus.valid_o, bus.iter_sel_o, bus.iter_en_o} !== 4'b1000) begin errors++; $display("FAIL single_done: got %b exp 1000", {bus.valid_o, bus.iter_sel_o, bus.iter_en_o}); end
    checks++; if (res_sel_o !== RES_SEL_ITER) begin errors++; $display("FAIL single_res_sel: got %0d exp %0d", res_sel_o, RES_SEL_ITER); end
    tick();
    @(negedge clk);
    checks++; if (dut.state_r !== ST_IDLE) begin errors++; $display("FAIL single_idle: got %0d exp %0d", dut.state_r, ST_IDLE); end
  endtask

  task automatic test_iter_back_to_back();
    do_flush();
    tick();
    ctl_i = MODE_ITER; bus.valid_i = 1'b1; bus.ready_i = 1'b1;
    @(negedge clk);
    checks++; if (bus.iter_start_o !== 2'b01) begin errors++; $display("FAIL b2b_start0: got %b exp 01", bus.iter_start_o); end
    tick(); @(negedge clk);
    checks++; if ({bus.ready_o, bus.iter_start_o} !== 3'b110) begin errors++; $display("FAIL b2b_start1: got %b exp 110", {bus.ready_o, bus.iter_start_o}); end
    for (int c = 2; c <= 3; c++) begin
      tick(); @(negedge clk);
      checks++; if ({bus.ready_o, bus.valid_o} !== 2'b00) begin errors++; $display("FAIL b2b_stall[c%0d]: got %b exp 00", c, {bus.ready_o, bus.valid_o}); end
    end
    tick(); @(negedge clk);
    checks++; if ({bus.ready_o, bus.valid_o, bus.iter_sel_o} !== 3'b010) begin errors++; $display("FAIL b2b_ret0: got %b exp 010", {bus.ready_o, bus.valid_o, bus.iter_sel_o}); end
    tick(); @(negedge clk);
    checks++; if ({bus.ready_o, bus.iter_start_o, bus.valid_o, bus.iter_sel_o} !== 5'b10111) begin errors++; $display("FAIL b2b_wrap_ret1: got %b exp 10111", {bus.ready_o, bus.iter_start_o, bus.valid_o, bus.iter_sel_o}); end
    for (int c = 6; c <= 8; c++) begin
      tick();
      bus.valid_i = 1'b0;
      @(negedge clk);
      checks++; if (bus.valid_o !== 1'b0) begin errors++; $display("FAIL b2b_wait[c%0d]: got %b exp 0", c, bus.valid_o); end
    end
    tick(); @(negedge clk);
    checks++; if ({bus.valid_o, bus.iter_sel_o} !== 2'b10) begin errors++; $display("FAIL b2b_ret2: got %b exp 10", {bus.valid_o, bus.iter_sel_o}); end
    tick(); @(negedge clk);
    checks++; if (dut.state_r !== ST_IDLE) begin errors++; $display("FAIL b2b_idle: got %0d exp %0d", dut.state_r, ST_IDLE); end
  endtask

  task automatic test_iter_hold();
    do_flush();
    tick();
    ctl_i = MODE_ITER; bus.valid_i = 1'b1; bus.ready_i = 1'b0;
    for (int c = 1; c <= 4; c++) begin
      tick();
      bus.valid_i = 1'b0;
    end
    for (int c = 4; c <= 6; c++) begin
      @(negedge clk);
      checks++; if ({bus.valid_o, bus.iter_en_o} !== 3'b100) begin errors++; $display("FAIL hold_valid[c%0d]: got %b exp 100", c, {bus.valid_o, bus.iter_en_o}); end
      tick();
    end
    bus.ready_i = 1'b1;
    @(negedge clk);
    checks++; if (bus.valid_o !== 1'b1) begin errors++; $display("FAIL hold_release: got %b exp 1", bus.valid_o); end
    tick(); @(negedge clk);
    checks++; if (dut.state_r !== ST_IDLE) begin errors++; $display("FAIL hold_idle: got %0d exp %0d", dut.state_r, ST_IDLE); end
  endtask

  task automatic test_pipe_credit();
    tick();
    ctl_i = MODE_PIPE; bus.valid_i = 1'b1; bus.ready_i = 1'b0; bus.pipe_valid_i = 1'b0;
    @(negedge clk);
    checks++; if ({bus.ready_o, bus.pipe_en_o} !== 2'b11) begin errors++; $display("FAIL pipe_first: got %b exp 11", {bus.ready_o, bus.pipe_en_o}); end
    for (int c = 1; c <= 2; c++) begin
      tick(); @(negedge clk);
      checks++; if (bus.ready_o !== 1'b1) begin errors++; $display("FAIL pipe_acc[c%0d]: got %b exp 1", c, bus.ready_o); end
    end
    tick(); @(negedge clk);
    checks++; if ({bus.ready_o, bus.pipe_en_o} !== 2'b01) begin errors++; $display("FAIL pipe_full: got %b exp 01", {bus.ready_o, bus.pipe_en_o}); end
    checks++; if (dut.count_r !== 2'd3) begin errors++; $display("FAIL pipe_count3: got %0d exp 3", dut.count_r); end
    tick();
    bus.pipe_valid_i = 1'b1; bus.ready_i = 1'b1;
    @(negedge clk);
    checks++; if ({bus.ready_o, bus.valid_o, bus.pipe_en_o} !== 3'b111) begin errors++; $display("FAIL pipe_swap: got %b exp 111", {bus.ready_o, bus.valid_o, bus.pipe_en_o}); end
    checks++; if (res_sel_o !== RES_SEL_PIPE) begin errors++; $display("FAIL pipe_res_sel: got %0d exp %0d", res_sel_o, RES_SEL_PIPE); end
    tick();
    bus.valid_i = 1'b0;
    @(negedge clk);
    checks++; if (dut.count_r !== 2'd3) begin errors++; $display("FAIL pipe_swap_count: got %0d exp 3", dut.count_r); end
    tick(); tick(); tick();
    @(negedge clk);
    checks++; if (dut.state_r !== ST_IDLE) begin errors++; $display("FAIL pipe_drain_idle: got %0d exp %0d", dut.state_r, ST_IDLE); end
    bus.pipe_valid_i = 1'b0; bus.ready_i = 1'b0;
  endtask

  task automatic test_mode_switch();
    do_flush();
    tick();
    ctl_i = MODE_PIPE; bus.valid_i = 1'b1; bus.ready_i = 1'b0; bus.pipe_valid_i = 1'b0;
    tick();
    tick();
    ctl_i = MODE_ITER;
    @(negedge clk);
    checks++; if (bus.ready_o !== 1'b0) begin errors++; $display("FAIL sw_stall: got %b exp 0", bus.ready_o); end
    checks++; if (dut.count_r !== 2'd2) begin errors++; $display("FAIL sw_count: got %0d exp 2", dut.count_r); end
    tick();
    bus.pipe_valid_i = 1'b1;
    @(negedge clk);
    checks++; if ({bus.pipe_en_o, bus.ready_o, bus.valid_o} !== 3'b001) begin errors++; $display("FAIL sw_backpressure: got %b exp 001", {bus.pipe_en_o, bus.ready_o, bus.valid_o}); end
    tick();
    bus.ready_i = 1'b1;
    @(negedge clk);
    checks++; if ({bus.pipe_en_o, bus.ready_o} !== 2'b10) begin errors++; $display("FAIL sw_drain1: got %b exp 10", {bus.pipe_en_o, bus.ready_o}); end
    tick(); @(negedge clk);
    checks++; if (bus.ready_o !== 1'b0) begin errors++; $display("FAIL sw_drain2: got %b exp 0", bus.ready_o); end
    tick();
    bus.pipe_valid_i = 1'b0;
    @(negedge clk);
    checks++; if ({dut.state_r == ST_IDLE, bus.ready_o, bus.iter_start_o} !== 4'b1101) begin errors++; $display("FAIL sw_accept: got %b exp 1101", {dut.state_r == ST_IDLE, bus.ready_o, bus.iter_start_o}); end
    tick();
    bus.valid_i = 1'b0;
    @(negedge clk);
    checks++; if (dut.state_r !== ST_ITER) begin errors++; $display("FAIL sw_iter_state: got %0d exp %0d", dut.state_r, ST_ITER); end
    tick(); tick(); tick();
    @(negedge clk);
    checks++; if (bus.valid_o !== 1'b1) begin errors++; $display("FAIL sw_iter_done: got %b exp 1", bus.valid_o); end
    tick();
  endtask

  task automatic test_flush();
    do_flush();
    tick();
    ctl_i = MODE_ITER; bus.valid_i = 1'b1; bus.ready_i = 1'b0;
    tick();
    bus.valid_i = 1'b0;
    tick();
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    @(negedge clk);
    checks++; if (dut.state_r !== ST_RESET) begin errors++; $display("FAIL flush_state: got %0d exp %0d", dut.state_r, ST_RESET); end
    checks++; if ({dut.busy_r, bus.valid_o, bus.ready_o, bus.iter_en_o} !== 6'b000000) begin errors++; $display("FAIL flush_clear: got %b exp 000000", {dut.busy_r, bus.valid_o, bus.ready_o, bus.iter_en_o}); end
    checks++; if (dut.disp_ptr_r !== 1'b0) begin errors++; $display("FAIL flush_disp: got %0d exp 0", dut.disp_ptr_r); end
    tick(); @(negedge clk);
    checks++; if (dut.state_r !== ST_IDLE) begin errors++; $display("FAIL flush_idle: got %0d exp %0d", dut.state_r, ST_IDLE); end
    // Same scenario, but the held result is wiped by an asynchronous reset.
    tick();
    bus.valid_i = 1'b1;
    for (int c = 1; c <= 4; c++) begin
      tick();
      bus.valid_i = 1'b0;
    end
    @(negedge clk);
    checks++; if (bus.valid_o !== 1'b1) begin errors++; $display("FAIL arst_pre_valid: got %b exp 1", bus.valid_o); end
    #2;
    rst_ni = 1'b0;
    #1;
    checks++; if (dut.state_r !== ST_RESET) begin errors++; $display("FAIL arst_state: got %0d exp %0d", dut.state_r, ST_RESET); end
    checks++; if ({dut.busy_r, dut.disp_ptr_r, dut.ret_ptr_r, dut.count_r, bus.valid_o} !== 7'b0000000) begin errors++; $display("FAIL arst_clear: got %b exp 0000000", {dut.busy_r, dut.disp_ptr_r, dut.ret_ptr_r, dut.count_r, bus.valid_o}); end
    tick();
    rst_ni = 1'b1;
    tick(); @(negedge clk);
    checks++; if (dut.state_r !== ST_IDLE) begin errors++; $display("FAIL arst_idle: got %0d exp %0d", dut.state_r, ST_IDLE); end
  endtask

  initial begin
    bus.valid_i = 1'b0;
    bus.comb_mode_i = 1'b0;
    bus.ready_i = 1'b0;
    bus.pipe_valid_i = 1'b0;
    test_reset();
    test_comb();
    test_iter_single();
    test_iter_back_to_back();
    test_iter_hold();
    test_pipe_credit();
    test_mode_switch();
    test_flush();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
